turn_sequencer: RTL and testbench

//  Parametrised game-flow controller for the board engine: welcome, init, then per-player

---
 rtl/turn_sequencer.sv | 133 +++++++++++++
 tb/tb_turn_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// Game-flow controller: welcome, board init, then an N-player turn loop with
// press/release of go, move validation, automatic passes, optional move timeout
// and game-over detection.
module turn_sequencer #(
  parameter int NUM_PLAYERS    = 2,
  parameter int PLAYER_W       = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_W           = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic                init_done,
  input  logic                ack,
  input  logic                nack,
  input  logic                no_moves,
  input  logic                game_end,
  output logic                init_start,
  output logic                new_move,
  output logic [PLAYER_W-1:0] player,
  output logic                pass_pulse,
  output logic                timeout,
  output logic                game_over
);

  typedef enum logic [2:0] {
    WELC       = 3'd0,
    INIT       = 3'd1,
    WAIT_PRESS = 3'd2,
    WAIT_REL   = 3'd3,
    VALIDATE   = 3'd4,
    PASS       = 3'd5,
    OVER       = 3'd6
  } state_t;

  localparam int PCW       = PLAYER_W + 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  state_t              state, state_nxt;
  logic [PLAYER_W-1:0] player_nxt;
  logic [PLAYER_W:0]   pass_cnt, pass_nxt, pass_inc;
  logic [TO_W-1:0]     to_cnt, to_nxt;
  logic                timeout_nxt;
  logic                to_hit;
  logic [PLAYER_W-1:0] player_adv;

  assign pass_inc   = pass_cnt + 1'b1;
  assign player_adv = (player == PLAYER_W'(NUM_PLAYERS - 1)) ? '0 : player + 1'b1;
  assign to_hit     = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TO_LAST_I));

  // Next-state, player/pass/timeout bookkeeping; game_end overrides everything mid-game
  always_comb begin
    state_nxt   = state;
    player_nxt  = player;
    pass_nxt    = pass_cnt;
    to_nxt      = to_cnt;
    timeout_nxt = 1'b0;
    case (state)
      WELC: if (go) state_nxt = INIT;
      INIT: begin
        if (init_done) begin
          state_nxt  = WAIT_PRESS;
          player_nxt = '0;
          pass_nxt   = '0;
        end
      end
      WAIT_PRESS: begin
        to_nxt = to_cnt + 1'b1;
        if (game_end)      state_nxt = OVER;
        else if (no_moves) state_nxt = PASS;
        else if (to_hit) begin
          state_nxt   = PASS;
          timeout_nxt = 1'b1;
        end
        else if (go)       state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (game_end) state_nxt = OVER;
        else if (!go) state_nxt = VALIDATE;
      end
      VALIDATE: begin
        if (game_end) state_nxt = OVER;
        else if (ack) begin
          state_nxt  = WAIT_PRESS;
          pass_nxt   = '0;
          player_nxt = player_adv;
        end
        else if (nack) state_nxt = WAIT_PRESS;
      end
      PASS: begin
        if (game_end) state_nxt = OVER;
        else begin
          pass_nxt = pass_inc;
          if (pass_inc == PCW'(NUM_PLAYERS)) state_nxt = OVER;
          else begin
            state_nxt  = WAIT_PRESS;
            player_nxt = player_adv;
          end
        end
      end
      OVER: if (go) state_nxt = WELC;
      default: state_nxt = WELC;
    endcase
    // Timeout window restarts on every entry into WAIT_PRESS
    if (state_nxt == WAIT_PRESS && state != WAIT_PRESS) to_nxt = '0;
  end

  // State and registered outputs; outputs reflect the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= WELC;
      player     <= '0;
      pass_cnt   <= '0;
      to_cnt     <= '0;
      init_start <= 1'b0;
      new_move   <= 1'b0;
      pass_pulse <= 1'b0;
      timeout    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      player     <= player_nxt;
      pass_cnt   <= pass_nxt;
      to_cnt     <= to_nxt;
      init_start <= (state_nxt == INIT);
      new_move   <= (state_nxt == VALIDATE);
      pass_pulse <= (state_nxt == PASS);
      timeout    <= timeout_nxt;
      game_over  <= (state_nxt == OVER);
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: 2 players, 8-cycle move timeout.
// Output vector: {init_start, new_move, player, pass_pulse, timeout, game_over}
// Stimulus vector: {go, init_done, ack, nack, no_moves, game_end}
module tb_turn_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic go = 1'b0, init_done = 1'b0, ack = 1'b0, nack = 1'b0;
  logic no_moves = 1'b0, game_end = 1'b0;
  logic init_start, new_move, pass_pulse, timeout, game_over;
  logic [0:0] player;
  logic [5:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [5:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  assign obs = {init_start, new_move, player, pass_pulse, timeout, game_over};

  turn_sequencer #(
    .NUM_PLAYERS   (2),
    .PLAYER_W      (1),
    .TIMEOUT_CYCLES(8),
    .TO_W          (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .init_done (init_done),
    .ack       (ack),
    .nack      (nack),
    .no_moves  (no_moves),
    .game_end  (game_end),
    .init_start(init_start),
    .new_move  (new_move),
    .player    (player),
    .pass_pulse(pass_pulse),
    .timeout   (timeout),
    .game_over (game_over)
  );

  task automatic test_reset();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    exp_t e;
    go = 1'b1; init_done = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    sb.push_back('{name: "reset_hold", v: 6'b000000});
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.v);
    end
    reset = 1'b1;
    stim = '{6'b110000, 6'b110000};
    expv = '{6'b100000, 6'b000000};
    for (int i = 0; i < stim.size(); i++) begin
      {go, init_done, ack, nack, no_moves, game_end} = stim[i];
      sb.push_back('{name: $sformatf("reset_start[%0d]", i), v: expv[i]});
      @(posedge clock); #1;
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      end
    end
    {go, init_done, ack, nack, no_moves, game_end} = 6'b000000;
  endtask

  task automatic test_turns();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    exp_t e;
    stim = '{6'b100000, 6'b000000, 6'b001000, 6'b100000, 6'b000000, 6'b001000};
    expv = '{6'b000000, 6'b010000, 6'b001000, 6'b001000, 6'b011000, 6'b000000};
    for (int i = 0; i < stim.size(); i++) begin
      {go, init_done, ack, nack, no_moves, game_end} = stim[i];
      sb.push_back('{name: $sformatf("turns[%0d]", i), v: expv[i]});
      @(posedge clock); #1;
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      end
    end
  endtask

  task automatic test_nack();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    exp_t e;
    stim = '{6'b100000, 6'b000000, 6'b000100, 6'b100000, 6'b000000, 6'b001100};
    expv = '{6'b000000, 6'b010000, 6'b000000, 6'b000000, 6'b010000, 6'b001000};
    for (int i = 0; i < stim.size(); i++) begin
      {go, init_done, ack, nack, no_moves, game_end} = stim[i];
      sb.push_back('{name: $sformatf("nack[%0d]", i), v: expv[i]});
      @(posedge clock); #1;
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      end
    end
  endtask

  // Player 1 passes, player 0 passes -> game over; then restart to player 0
  task automatic test_pass();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    exp_t e;
    stim = '{6'b000010, 6'b000010, 6'b000010, 6'b000000, 6'b000000, 6'b000000,
             6'b100000, 6'b110000, 6'b010000};
    expv = '{6'b001100, 6'b000000, 6'b000100, 6'b000001, 6'b000001, 6'b000001,
             6'b000000, 6'b100000, 6'b000000};
    for (int i = 0; i < stim.size(); i++) begin
      {go, init_done, ack, nack, no_moves, game_end} = stim[i];
      sb.push_back('{name: $sformatf("pass[%0d]", i), v: expv[i]});
      @(posedge clock); #1;
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      end
    end
  endtask

  // 7 idle cycles stay put; 8th cycle times out even with go pressed
  task automatic test_timeout();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    exp_t e;
    stim = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
             6'b000000, 6'b100000, 6'b100000};
    expv = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
             6'b000000, 6'b000110, 6'b001000};
    for (int i = 0; i < stim.size(); i++) begin
      {go, init_done, ack, nack, no_moves, game_end} = stim[i];
      sb.push_back('{name: $sformatf("timeout[%0d]", i), v: expv[i]});
      @(posedge clock); #1;
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      end
    end
  endtask

  // game_end while waiting for release; player index is kept until next INIT
  task automatic test_game_end();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    exp_t e;
    stim = '{6'b100000, 6'b100001, 6'b100000, 6'b110000, 6'b010000};
    expv = '{6'b001000, 6'b001001, 6'b001000, 6'b101000, 6'b000000};
    for (int i = 0; i < stim.size(); i++) begin
      {go, init_done, ack, nack, no_moves, game_end} = stim[i];
      sb.push_back('{name: $sformatf("game_end[%0d]", i), v: expv[i]});
      @(posedge clock); #1;
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] stim[$];
    logic [5:0] expv[$];
    exp_t e;
    stim = '{6'b100000, 6'b000000};
    expv = '{6'b000000, 6'b010000};
    for (int i = 0; i < stim.size(); i++) begin
      {go, init_done, ack, nack, no_moves, game_end} = stim[i];
      sb.push_back('{name: $sformatf("mid_setup[%0d]", i), v: expv[i]});
      @(posedge clock); #1;
      e = sb.pop_front(); n_cmp++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", e.name, obs, e.v);
      end
    end
    #1;
    ack = 1'b1;
    reset = 1'b0;
    #1;
    sb.push_back('{name: "mid_async", v: 6'b000000});
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.v);
    end
    @(posedge clock); #1;
    sb.push_back('{name: "mid_held", v: 6'b000000});
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.v);
    end
    reset = 1'b1;
    ack = 1'b0;
    @(posedge clock); #1;
    sb.push_back('{name: "mid_release", v: 6'b000000});
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.v);
    end
    go = 1'b1;
    @(posedge clock); #1;
    sb.push_back('{name: "mid_restart", v: 6'b100000});
    e = sb.pop_front(); n_cmp++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", e.name, obs, e.v);
    end
    go = 1'b0;
  endtask

  initial begin
    test_reset();
    test_turns();
    test_nack();
    test_pass();
    test_timeout();
    test_game_end();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
